// File: rtl/switch_debounce_pair_if.sv
// rtl/switch_debounce_pair_if.sv - switch pins and conditioned outputs of switch_debounce_pair
//
// Purpose: bundles the raw switch inputs and the debounced level/pulse/count
// outputs so the conditioner and its consumer share one connection.
// Signals:
//   x_raw, y_raw     raw switch levels, asynchronous to the conditioner clock
//   x_db, y_db       debounced levels
//   x_rise, x_fall   one-cycle pulses on debounced X 0->1 / 1->0
//   y_rise, y_fall   the same for Y
//   change_cnt       debounced transitions on both channels, modulo 256
//   led              registered x_db ^ y_db (0 when the parity LED is not built)
// Modports:
//   master           the side that owns the switches and consumes the outputs
//   slave            the conditioner itself

interface switch_debounce_pair_if;
  logic       x_raw;
  logic       y_raw;
  logic       x_db;
  logic       y_db;
  logic       x_rise;
  logic       x_fall;
  logic       y_rise;
  logic       y_fall;
  logic [7:0] change_cnt;
  logic       led;

  modport master (
    output x_raw, y_raw,
    input  x_db, y_db, x_rise, x_fall, y_rise, y_fall, change_cnt, led
  );

  modport slave (
    input  x_raw, y_raw,
    output x_db, y_db, x_rise, x_fall, y_rise, y_fall, change_cnt, led
  );
endinterface

// File: rtl/switch_debounce_pair.sv
// rtl/switch_debounce_pair.sv - two-channel switch synchronizer and debouncer
//
// Purpose: synchronizes raw X/Y switch inputs into clk, debounces each with a
// stability counter, and emits clean levels, one-cycle rise/fall pulses, a
// modulo-256 count of debounced transitions and a parity LED.
// Parameters:
//   DB_CYCLES  consecutive mismatching cycles needed to accept a new level (1 .. 2^CNT_W-1)
//   CNT_W      width of each per-channel stability counter
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   sw         switch_debounce_pair_if.slave: raw inputs in, conditioned outputs out
// Build option:
//   SWITCH_DEBOUNCE_PARITY_EN  when defined, led is a register loaded with
//                              x_db ^ y_db; otherwise led is constant 0.

module switch_debounce_pair #(
  parameter int DB_CYCLES = 50000,
  parameter int CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  switch_debounce_pair_if.slave sw
);

  generate
    if (DB_CYCLES < 1 || DB_CYCLES >= (1 << CNT_W)) begin : g_bad_db_cycles
      $error("switch_debounce_pair: DB_CYCLES must be in 1 .. 2^CNT_W-1");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  // Channel index 0 is X, 1 is Y.
  logic [1:0]       raw;
  logic [1:0]       s1;
  logic [1:0]       s2;
  logic [1:0]       db;
  logic [1:0]       rise;
  logic [1:0]       fall;
  logic [1:0]       accept;
  logic [CNT_W-1:0] cnt [2];
  logic [7:0]       change_cnt;

  assign raw = {sw.y_raw, sw.x_raw};

  // A channel accepts its synchronized level on the edge that completes
  // DB_CYCLES consecutive cycles of disagreement with the debounced level.
  always_comb begin
    accept = '0;
    for (int i = 0; i < 2; i++) begin
      accept[i] = (s2[i] != db[i]) && (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1         <= '0;
      s2         <= '0;
      db         <= '0;
      rise       <= '0;
      fall       <= '0;
      change_cnt <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 2; i++) begin
        // Any return to the debounced level restarts the stability count,
        // which is what rejects glitches and bounce trains.
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          db[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
        rise[i] <= accept[i] & s2[i];
        fall[i] <= accept[i] & ~s2[i];
      end
      change_cnt <= change_cnt + 8'(accept[0]) + 8'(accept[1]);
    end
  end

`ifdef SWITCH_DEBOUNCE_PARITY_EN
  logic led_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q <= 1'b0;
    end else begin
      led_q <= db[0] ^ db[1];
    end
  end

  assign sw.led = led_q;
`else
  assign sw.led = 1'b0;
`endif

  assign sw.x_db       = db[0];
  assign sw.y_db       = db[1];
  assign sw.x_rise     = rise[0];
  assign sw.x_fall     = fall[0];
  assign sw.y_rise     = rise[1];
  assign sw.y_fall     = fall[1];
  assign sw.change_cnt = change_cnt;

endmodule

// File: tb/tb_switch_debounce_pair.sv
// tb/tb_switch_debounce_pair.sv - self-checking bench for switch_debounce_pair

module tb_switch_debounce_pair;

  localparam int DB    = 4;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  switch_debounce_pair_if sw ();

  switch_debounce_pair #(
    .DB_CYCLES(DB),
    .CNT_W    (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw (sw)
  );

  int checks = 0;
  int errors = 0;
  bit cur_x  = 1'b0;
  bit cur_y  = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a level is accepted once the last DB synchronized samples
  // all disagree with the current debounced level. The synchronized sample seen
  // at an edge is the raw value sampled two edges earlier (0 straight after reset).
  bit [1:0]    m_hist  [2];
  int          m_hist_n[2];
  bit [DB-1:0] m_win   [2];
  int          m_win_n [2];
  bit          m_db    [2];
  bit          m_rise  [2];
  bit          m_fall  [2];
  int          m_cc;
  bit          m_led;

  task automatic model_edge(input bit r, input bit xr, input bit yr);
    bit          raw [2];
    bit          s2_old;
    bit          acc;
    bit          led_next;
    bit [DB-1:0] ones;
    ones = '1;
    if (r) begin
      for (int c = 0; c < 2; c++) begin
        m_hist[c] = '0; m_hist_n[c] = 0; m_win[c] = '0; m_win_n[c] = 0;
        m_db[c] = 1'b0; m_rise[c] = 1'b0; m_fall[c] = 1'b0;
      end
      m_cc  = 0;
      m_led = 1'b0;
    end else begin
      raw[0]   = xr;
      raw[1]   = yr;
      led_next = m_db[0] ^ m_db[1];
      for (int c = 0; c < 2; c++) begin
        s2_old      = (m_hist_n[c] >= 2) ? m_hist[c][1] : 1'b0;
        m_hist[c]   = {m_hist[c][0], raw[c]};
        m_hist_n[c] = (m_hist_n[c] < 2) ? m_hist_n[c] + 1 : 2;
        m_win[c]    = {m_win[c][DB-2:0], s2_old};
        m_win_n[c]  = (m_win_n[c] < DB) ? m_win_n[c] + 1 : DB;
        acc = (m_win_n[c] >= DB) && (m_win[c] == (m_db[c] ? '0 : ones));
        m_rise[c] = acc && s2_old;
        m_fall[c] = acc && !s2_old;
        if (acc) m_db[c] = s2_old;
        m_cc = (m_cc + int'(acc)) % 256;
      end
`ifdef SWITCH_DEBOUNCE_PARITY_EN
      m_led = led_next;
`else
      m_led = 1'b0;
`endif
    end
  endtask

  task automatic model_check();
    chk("m_x_db", sw.x_db, m_db[0]);
    chk("m_y_db", sw.y_db, m_db[1]);
    chk("m_x_rise", sw.x_rise, m_rise[0]);
    chk("m_x_fall", sw.x_fall, m_fall[0]);
    chk("m_y_rise", sw.y_rise, m_rise[1]);
    chk("m_y_fall", sw.y_fall, m_fall[1]);
    chk("m_change_cnt", sw.change_cnt, 8'(m_cc));
    chk("m_led", sw.led, m_led);
  endtask

  task automatic step(input bit r, input bit xr, input bit yr);
    @(negedge clk);
    rst      = r;
    sw.x_raw = xr;
    sw.y_raw = yr;
    @(posedge clk);
    model_edge(r, xr, yr);
    #1;
    model_check();
  endtask

  typedef struct {
    bit         rst;
    bit         x;
    bit         y;
    bit         x_db;
    bit         x_rise;
    bit         y_db;
    logic [7:0] cc;
    bit         led;
  } vec_t;

  vec_t vecs [31];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bit       led_e;
    bit       found;
    bit       seen_255;
    bit       wrapped;
    int       saved;

    sw.x_raw = 1'b0;
    sw.y_raw = 1'b0;

    // Reset, 20 quiet cycles, then a clean X press sampled at row 23 (edge k).
    for (int i = 0; i < 31; i++) begin
      vecs[i] = '{rst: (i < 3), x: (i >= 23), y: 1'b0,
                  x_db: 1'b0, x_rise: 1'b0, y_db: 1'b0, cc: 8'd0, led: 1'b0};
    end
    vecs[28].x_db = 1'b1; vecs[28].x_rise = 1'b1; vecs[28].cc = 8'd1;
    for (int i = 29; i < 31; i++) begin
      vecs[i].x_db = 1'b1; vecs[i].cc = 8'd1; vecs[i].led = 1'b1;
    end

    for (int i = 0; i < 31; i++) begin
      step(vecs[i].rst, vecs[i].x, vecs[i].y);
`ifdef SWITCH_DEBOUNCE_PARITY_EN
      led_e = vecs[i].led;
`else
      led_e = 1'b0;
`endif
      chk("tbl_x_db", sw.x_db, vecs[i].x_db);
      chk("tbl_x_rise", sw.x_rise, vecs[i].x_rise);
      chk("tbl_y_db", sw.y_db, vecs[i].y_db);
      chk("tbl_change_cnt", sw.change_cnt, vecs[i].cc);
      chk("tbl_led", sw.led, led_e);
    end
    cur_x = 1'b1;

    // Release X, then a bounce train that never stays high for DB cycles.
    cur_x = 1'b0;
    repeat (8) step(1'b0, cur_x, cur_y);
    chk("release_cnt", sw.change_cnt, 8'd2);
    begin
      bit pat [17];
      for (int i = 0; i < 17; i++) pat[i] = 1'b0;
      pat[0] = 1; pat[1] = 1; pat[2] = 1; pat[4] = 1; pat[5] = 1;
      for (int i = 0; i < 17; i++) begin
        step(1'b0, pat[i], cur_y);
        chk("glitch_x_db", sw.x_db, 1'b0);
        chk("glitch_x_rise", sw.x_rise, 1'b0);
        chk("glitch_x_fall", sw.x_fall, 1'b0);
      end
    end
    chk("glitch_cnt", sw.change_cnt, 8'd2);

    // Simultaneous X and Y press.
    saved = m_cc;
    found = 1'b0;
    cur_x = 1'b1;
    cur_y = 1'b1;
    for (int i = 0; i < 12 && !found; i++) begin
      step(1'b0, cur_x, cur_y);
      chk("simul_led", sw.led, 1'b0);
      if (sw.x_rise === 1'b1) begin
        found = 1'b1;
        chk("simul_y_rise", sw.y_rise, 1'b1);
        chk("simul_cnt", sw.change_cnt, 8'(saved + 2));
      end
    end
    chk("simul_found", found, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, cur_x, cur_y);
      chk("simul_led_after", sw.led, 1'b0);
    end
    cur_x = 1'b0;
    cur_y = 1'b0;
    repeat (8) step(1'b0, cur_x, cur_y);

    // Walk change_cnt to 254, then 256 more X transitions through the wrap.
    for (int n = 0; n < 300 && m_cc != 254; n++) begin
      cur_x = ~cur_x;
      repeat (8) step(1'b0, cur_x, cur_y);
    end
    chk("wrap_start", sw.change_cnt, 8'd254);
    seen_255 = 1'b0;
    wrapped  = 1'b0;
    for (int n = 0; n < 256; n++) begin
      cur_x = ~cur_x;
      for (int j = 0; j < 8; j++) begin
        step(1'b0, cur_x, cur_y);
        if (sw.change_cnt == 8'd255) seen_255 = 1'b1;
        if (seen_255 && sw.change_cnt == 8'd0) wrapped = 1'b1;
      end
    end
    chk("wrap_through_zero", wrapped, 1'b1);
    chk("wrap_end", sw.change_cnt, 8'd254);

    // Reset while Y's stability count is at 2.
    cur_y = 1'b1;
    repeat (4) step(1'b0, cur_x, cur_y);
    repeat (2) step(1'b1, cur_x, cur_y);
    for (int e = 1; e <= 10; e++) begin
      step(1'b0, cur_x, cur_y);
      chk("rstmid_y_db", sw.y_db, (e >= DB + 2) ? 8'd1 : 8'd0);
      chk("rstmid_y_rise", sw.y_rise, (e == DB + 2) ? 8'd1 : 8'd0);
    end

    // Random activity against the model, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(4, 0) == 0) cur_x = ~cur_x;
      if ($urandom_range(4, 0) == 0) cur_y = ~cur_y;
      step(($urandom_range(299, 0) == 0), cur_x, cur_y);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
